pcie_tx_arbiter: RTL and testbench

//  Shares the PCIe core VC0 transmit port (16-bit tx_data/tx_st/tx_end, tx_req/tx_rdy) between two TLP sources:
//  src0 = completion generator, src1 = posted-write (DMA) engine. Checks posted/completion credits,

---
 rtl/pcie_tx_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_pcie_tx_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_arbiter.sv
// pcie_tx_arbiter
//   Shares the PCIe core VC0 transmit port between two TLP sources:
//   src0 (completion generator) and src1 (posted-write DMA engine).
//   The block checks credits for the requesting TLP's class, runs the
//   tx_req/tx_rdy handshake with the core, grants one source and muxes its
//   stream onto the core port until tx_end.
//
// Ports
//   clk_125, core_rst_n          clock, synchronous active-low reset
//   srcN_req/cpl/len/nodata      per-source TLP request and credit descriptor
//   srcN_data/st/end             per-source stream word, first/last markers
//   srcN_gnt                     grant level; the source streams while high
//   tx_req_vc0, tx_rdy_vc0       request/ready handshake with the core
//   tx_data/st/end_vc0           muxed stream to the core
//   tx_ca_ph/pd/cplh/cpld_vc0    available credits (top bit = infinite)
//   tx_ca_p/cpl_recheck_vc0      core asks for a credit recheck per class
//   busy                         arbiter is not idle
//   gnt_abort                    one-cycle pulse when a grant times out
//
// States
//   state    | meaning
//   S_IDLE   | arbitrating between eligible requests
//   S_REQ    | tx_req_vc0 raised for the latched source, waiting on tx_rdy_vc0
//   S_STREAM | source granted, its stream is muxed to the core until end
module pcie_tx_arbiter #(
  parameter int GNT_TIMEOUT = 64
) (
  input  logic        clk_125,
  input  logic        core_rst_n,
  input  logic        src0_req,
  input  logic        src0_cpl,
  input  logic [9:0]  src0_len,
  input  logic        src0_nodata,
  input  logic [15:0] src0_data,
  input  logic        src0_st,
  input  logic        src0_end,
  output logic        src0_gnt,
  input  logic        src1_req,
  input  logic        src1_cpl,
  input  logic [9:0]  src1_len,
  input  logic        src1_nodata,
  input  logic [15:0] src1_data,
  input  logic        src1_st,
  input  logic        src1_end,
  output logic        src1_gnt,
  output logic        tx_req_vc0,
  input  logic        tx_rdy_vc0,
  output logic [15:0] tx_data_vc0,
  output logic        tx_st_vc0,
  output logic        tx_end_vc0,
  input  logic [8:0]  tx_ca_ph_vc0,
  input  logic [12:0] tx_ca_pd_vc0,
  input  logic [8:0]  tx_ca_cplh_vc0,
  input  logic [12:0] tx_ca_cpld_vc0,
  input  logic        tx_ca_p_recheck_vc0,
  input  logic        tx_ca_cpl_recheck_vc0,
  output logic        busy,
  output logic        gnt_abort
);

  localparam int TW = $clog2(GNT_TIMEOUT);
  // Down-counter loaded on grant; terminal count 0 marks the last allowed
  // cycle without a start-of-stream.
  localparam logic [TW-1:0] T_LOAD = TW'(GNT_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STREAM} state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          cls_q, cls_d;
  logic [8:0]    need_q, need_d;
  logic          last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          seen_q, seen_d;
  logic          abort_q, abort_d;

  // Data credits in 4-DW units; len 0 encodes 1024 DW, so max need is 256.
  function automatic logic [8:0] calc_need(input logic nodata, input logic [9:0] len);
    logic [10:0] len_eff;
    logic [10:0] rounded;
    len_eff = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    rounded = len_eff + 11'd3;
    return nodata ? 9'd0 : rounded[10:2];
  endfunction

  function automatic logic credit_ok(input logic cls, input logic [8:0] need,
                                     input logic [8:0] ph, input logic [12:0] pd,
                                     input logic [8:0] cplh, input logic [12:0] cpld);
    logic [8:0]  hdr;
    logic [12:0] dat;
    hdr = cls ? cplh : ph;
    dat = cls ? cpld : pd;
    return (hdr[8] | (|hdr[7:0])) & (dat[12] | (dat[11:0] >= {3'b000, need}));
  endfunction

  logic [8:0]  need0, need1;
  logic        elig0, elig1, pick;
  logic        ok_lat, recheck;
  logic [15:0] sel_data;
  logic        sel_st, sel_end, gnt_on;

  assign need0 = calc_need(src0_nodata, src0_len);
  assign need1 = calc_need(src1_nodata, src1_len);
  assign elig0 = src0_req & credit_ok(src0_cpl, need0, tx_ca_ph_vc0, tx_ca_pd_vc0,
                                      tx_ca_cplh_vc0, tx_ca_cpld_vc0);
  assign elig1 = src1_req & credit_ok(src1_cpl, need1, tx_ca_ph_vc0, tx_ca_pd_vc0,
                                      tx_ca_cplh_vc0, tx_ca_cpld_vc0);
  // On a tie the source that did not finish last wins.
  assign pick  = (elig0 & elig1) ? ~last_q : elig1;

  assign ok_lat  = credit_ok(cls_q, need_q, tx_ca_ph_vc0, tx_ca_pd_vc0,
                             tx_ca_cplh_vc0, tx_ca_cpld_vc0);
  assign recheck = cls_q ? tx_ca_cpl_recheck_vc0 : tx_ca_p_recheck_vc0;

  assign sel_data = sel_q ? src1_data : src0_data;
  assign sel_st   = sel_q ? src1_st   : src0_st;
  assign sel_end  = sel_q ? src1_end  : src0_end;
  assign gnt_on   = (state_q == S_STREAM);

  assign src0_gnt    = gnt_on & ~sel_q;
  assign src1_gnt    = gnt_on &  sel_q;
  assign tx_req_vc0  = (state_q == S_REQ);
  assign tx_data_vc0 = gnt_on ? sel_data : 16'h0000;
  assign tx_st_vc0   = gnt_on & sel_st;
  assign tx_end_vc0  = gnt_on & sel_end;
  assign busy        = (state_q != S_IDLE);
  assign gnt_abort   = abort_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cls_d   = cls_q;
    need_d  = need_q;
    last_d  = last_q;
    timer_d = timer_q;
    seen_d  = seen_q;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (elig0 | elig1) begin
          sel_d   = pick;
          cls_d   = pick ? src1_cpl : src0_cpl;
          need_d  = pick ? need1 : need0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A failing recheck overrides a simultaneous tx_rdy.
        if (recheck && !ok_lat) begin
          state_d = S_IDLE;
        end else if (tx_rdy_vc0) begin
          state_d = S_STREAM;
          timer_d = T_LOAD;
          seen_d  = 1'b0;
        end
      end
      S_STREAM: begin
        if (sel_end) begin
          last_d  = sel_q;
          state_d = S_IDLE;
        end else if (!seen_q) begin
          if (sel_st) begin
            seen_d = 1'b1;
          end else if (timer_q == '0) begin
            abort_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_125) begin
    if (!core_rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      cls_q   <= 1'b0;
      need_q  <= '0;
      last_q  <= 1'b1;
      timer_q <= '0;
      seen_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cls_q   <= cls_d;
      need_q  <= need_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      seen_q  <= seen_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
module tb_pcie_tx_arbiter;
  localparam int GNT_TIMEOUT = 64;

  logic        clk_125 = 1'b0;
  logic        core_rst_n;
  logic        src0_req, src0_cpl, src0_nodata, src0_st, src0_end, src0_gnt;
  logic        src1_req, src1_cpl, src1_nodata, src1_st, src1_end, src1_gnt;
  logic [9:0]  src0_len, src1_len;
  logic [15:0] src0_data, src1_data, tx_data_vc0;
  logic        tx_req_vc0, tx_rdy_vc0, tx_st_vc0, tx_end_vc0;
  logic [8:0]  tx_ca_ph_vc0, tx_ca_cplh_vc0;
  logic [12:0] tx_ca_pd_vc0, tx_ca_cpld_vc0;
  logic        tx_ca_p_recheck_vc0, tx_ca_cpl_recheck_vc0;
  logic        busy, gnt_abort;

  int n_checks = 0;
  int n_pass   = 0;

  always #4 clk_125 = ~clk_125;

  pcie_tx_arbiter #(.GNT_TIMEOUT(GNT_TIMEOUT)) dut (
    .clk_125(clk_125), .core_rst_n(core_rst_n),
    .src0_req(src0_req), .src0_cpl(src0_cpl), .src0_len(src0_len), .src0_nodata(src0_nodata),
    .src0_data(src0_data), .src0_st(src0_st), .src0_end(src0_end), .src0_gnt(src0_gnt),
    .src1_req(src1_req), .src1_cpl(src1_cpl), .src1_len(src1_len), .src1_nodata(src1_nodata),
    .src1_data(src1_data), .src1_st(src1_st), .src1_end(src1_end), .src1_gnt(src1_gnt),
    .tx_req_vc0(tx_req_vc0), .tx_rdy_vc0(tx_rdy_vc0), .tx_data_vc0(tx_data_vc0),
    .tx_st_vc0(tx_st_vc0), .tx_end_vc0(tx_end_vc0),
    .tx_ca_ph_vc0(tx_ca_ph_vc0), .tx_ca_pd_vc0(tx_ca_pd_vc0),
    .tx_ca_cplh_vc0(tx_ca_cplh_vc0), .tx_ca_cpld_vc0(tx_ca_cpld_vc0),
    .tx_ca_p_recheck_vc0(tx_ca_p_recheck_vc0), .tx_ca_cpl_recheck_vc0(tx_ca_cpl_recheck_vc0),
    .busy(busy), .gnt_abort(gnt_abort)
  );

  typedef struct {
    bit          cpl;
    bit          nodata;
    logic [9:0]  len;
    logic [8:0]  ph;
    logic [12:0] pd;
    logic [8:0]  cplh;
    logic [12:0] cpld;
    bit          exp_req;
  } vec_t;

  vec_t vec[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_125);
    #1;
  endtask

  task automatic clear_inputs();
    src0_req = 0; src0_cpl = 0; src0_len = '0; src0_nodata = 0; src0_data = '0; src0_st = 0; src0_end = 0;
    src1_req = 0; src1_cpl = 0; src1_len = '0; src1_nodata = 0; src1_data = '0; src1_st = 0; src1_end = 0;
    tx_rdy_vc0 = 0; tx_ca_ph_vc0 = '0; tx_ca_pd_vc0 = '0; tx_ca_cplh_vc0 = '0; tx_ca_cpld_vc0 = '0;
    tx_ca_p_recheck_vc0 = 0; tx_ca_cpl_recheck_vc0 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    core_rst_n = 0;
    tick();
    core_rst_n = 1;
  endtask

  task automatic drive_src(input int n, input bit st, input bit en);
    if (n == 0) begin src0_st = st; src0_end = en; end
    else begin src1_st = st; src1_end = en; end
  endtask

  task automatic wait_gnt(output int who);
    who = -1;
    for (int c = 0; c < 10 && who < 0; c++) begin
      tick();
      if (src0_gnt && src1_gnt) who = 2;
      else if (src0_gnt) who = 0;
      else if (src1_gnt) who = 1;
    end
  endtask

  // ---------------- reference model for the random phase ----------------
  int m_req, m_own, m_last, m_wait, m_need;
  bit m_cls, m_started, m_abort;

  function automatic int need_of(input bit nd, input int len);
    int l;
    l = (len == 0) ? 1024 : len;
    return nd ? 0 : (l + 3) / 4;
  endfunction

  function automatic bit fits(input bit cpl, input int need);
    int h, d;
    h = cpl ? int'(tx_ca_cplh_vc0) : int'(tx_ca_ph_vc0);
    d = cpl ? int'(tx_ca_cpld_vc0) : int'(tx_ca_pd_vc0);
    return ((h >= 256) || (h % 256 >= 1)) && ((d >= 4096) || (d % 4096 >= need));
  endfunction

  function automatic bit s_st(input int n);
    return (n == 1) ? src1_st : src0_st;
  endfunction

  function automatic bit s_end(input int n);
    return (n == 1) ? src1_end : src0_end;
  endfunction

  task automatic model_step();
    bit e0, e1;
    int w;
    if (!core_rst_n) begin
      m_req = -1; m_own = -1; m_last = 1; m_abort = 0; m_wait = 0; m_started = 0;
      return;
    end
    m_abort = 0;
    if (m_own >= 0) begin
      if (s_end(m_own)) begin
        m_last = m_own; m_own = -1;
      end else if (!m_started) begin
        if (s_st(m_own)) m_started = 1;
        else begin
          m_wait++;
          if (m_wait >= GNT_TIMEOUT) begin m_own = -1; m_abort = 1; end
        end
      end
    end else if (m_req >= 0) begin
      if ((m_cls ? tx_ca_cpl_recheck_vc0 : tx_ca_p_recheck_vc0) && !fits(m_cls, m_need)) m_req = -1;
      else if (tx_rdy_vc0) begin m_own = m_req; m_req = -1; m_wait = 0; m_started = 0; end
    end else begin
      e0 = src0_req && fits(src0_cpl, need_of(src0_nodata, int'(src0_len)));
      e1 = src1_req && fits(src1_cpl, need_of(src1_nodata, int'(src1_len)));
      if (e0 || e1) begin
        w = (e0 && e1) ? 1 - m_last : (e0 ? 0 : 1);
        m_req  = w;
        m_cls  = w ? src1_cpl : src0_cpl;
        m_need = w ? need_of(src1_nodata, int'(src1_len)) : need_of(src0_nodata, int'(src0_len));
      end
    end
  endtask

  function automatic logic [8:0] rnd_hdr();
    case ($urandom_range(0, 3))
      0: return 9'd0;
      1: return 9'($urandom_range(1, 3));
      2: return 9'h100;
      default: return 9'($urandom_range(0, 511));
    endcase
  endfunction

  function automatic logic [12:0] rnd_dat();
    case ($urandom_range(0, 3))
      0: return 13'h1000 | 13'($urandom_range(0, 15));
      1: return 13'($urandom_range(0, 300));
      2: return 13'($urandom_range(0, 4095));
      default: return 13'd0;
    endcase
  endfunction

  task automatic randomize_inputs();
    core_rst_n  = ($urandom_range(0, 299) != 0);
    src0_req    = ($urandom_range(0, 3) != 0);
    src1_req    = ($urandom_range(0, 3) != 0);
    src0_cpl    = $urandom_range(0, 1) != 0;
    src1_cpl    = $urandom_range(0, 1) != 0;
    src0_len    = $urandom_range(0, 1) != 0 ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 20));
    src1_len    = $urandom_range(0, 1) != 0 ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 20));
    src0_nodata = ($urandom_range(0, 3) == 0);
    src1_nodata = ($urandom_range(0, 3) == 0);
    src0_data   = 16'($urandom);
    src1_data   = 16'($urandom);
    src0_st     = ($urandom_range(0, 9) < 3);
    src1_st     = ($urandom_range(0, 9) < 3);
    src0_end    = ($urandom_range(0, 9) < 2);
    src1_end    = ($urandom_range(0, 9) < 2);
    tx_rdy_vc0  = $urandom_range(0, 1) != 0;
    tx_ca_p_recheck_vc0   = ($urandom_range(0, 4) == 0);
    tx_ca_cpl_recheck_vc0 = ($urandom_range(0, 4) == 0);
    tx_ca_ph_vc0   = rnd_hdr();
    tx_ca_cplh_vc0 = rnd_hdr();
    tx_ca_pd_vc0   = rnd_dat();
    tx_ca_cpld_vc0 = rnd_dat();
  endtask

  initial begin
    int who;
    int cnt_g, cnt_a, abort_at;
    logic [22:0] exp_v, got_v;
    bit e_st, e_end;
    logic [15:0] e_data;

    //            cpl nd len    ph      pd        cplh   cpld     exp
    vec[0]  = '{0, 0, 10'd17,  9'd1,   13'd4,    9'd0,  13'd0,    0};
    vec[1]  = '{0, 0, 10'd17,  9'd1,   13'd5,    9'd0,  13'd0,    1};
    vec[2]  = '{0, 0, 10'd0,   9'd1,   13'd255,  9'd0,  13'd0,    0};
    vec[3]  = '{0, 0, 10'd0,   9'd1,   13'd256,  9'd0,  13'd0,    1};
    vec[4]  = '{0, 0, 10'd0,   9'd1,   13'h1000, 9'd0,  13'd0,    1};
    vec[5]  = '{0, 0, 10'd4,   9'd0,   13'd8,    9'd5,  13'd8,    0};
    vec[6]  = '{0, 0, 10'd4,   9'h100, 13'd1,    9'd0,  13'd0,    1};
    vec[7]  = '{0, 1, 10'd17,  9'd1,   13'd0,    9'd0,  13'd0,    1};
    vec[8]  = '{1, 0, 10'd1,   9'd0,   13'd0,    9'd4,  13'd4,    1};
    vec[9]  = '{1, 0, 10'd1,   9'd4,   13'd4,    9'd0,  13'd4,    0};
    vec[10] = '{1, 0, 10'd5,   9'd0,   13'd0,    9'd1,  13'd1,    0};
    vec[11] = '{1, 0, 10'd1023,9'd0,   13'd0,    9'd1,  13'd256,  1};
    vec[12] = '{1, 0, 10'd8,   9'd0,   13'd0,    9'd1,  13'd2,    1};

    do_reset();
    check("rst_busy", busy, 0);
    check("rst_req", tx_req_vc0, 0);
    check("rst_gnt", {src0_gnt, src1_gnt, gnt_abort}, 0);

    // credit eligibility table, applied through src1
    for (int i = 0; i < 13; i++) begin
      do_reset();
      src1_cpl = vec[i].cpl; src1_nodata = vec[i].nodata; src1_len = vec[i].len;
      tx_ca_ph_vc0 = vec[i].ph; tx_ca_pd_vc0 = vec[i].pd;
      tx_ca_cplh_vc0 = vec[i].cplh; tx_ca_cpld_vc0 = vec[i].cpld;
      src1_req = 1;
      tick();
      check($sformatf("vec%0d_req", i), tx_req_vc0, vec[i].exp_req);
    end

    // single completion, tx_rdy in the third request cycle, 8-word stream
    do_reset();
    tx_ca_cplh_vc0 = 9'd4; tx_ca_cpld_vc0 = 13'd4;
    src0_req = 1; src0_cpl = 1; src0_len = 10'd1;
    src1_data = 16'h5555; src1_st = 1; src1_end = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t1_req_c%0d", c), tx_req_vc0, 1);
    end
    tx_rdy_vc0 = 1;
    tick();
    tx_rdy_vc0 = 0; src0_req = 0;
    check("t1_req_drop", tx_req_vc0, 0);
    for (int i = 0; i < 8; i++) begin
      src0_data = 16'hA000 + 16'(i); src0_st = (i == 0); src0_end = (i == 7);
      #1;
      check($sformatf("t1_w%0d", i), {src0_gnt, src1_gnt, tx_st_vc0, tx_end_vc0, tx_data_vc0},
            {1'b1, 1'b0, (i == 0), (i == 7), 16'hA000 + 16'(i)});
      tick();
    end
    src0_st = 0; src0_end = 0;
    check("t1_after", {src0_gnt, busy, tx_data_vc0}, 0);

    // simultaneous requests alternate, starting with src0
    do_reset();
    tx_ca_ph_vc0 = 9'h100; tx_ca_pd_vc0 = 13'h1000; tx_ca_cplh_vc0 = 9'h100; tx_ca_cpld_vc0 = 13'h1000;
    src0_req = 1; src0_cpl = 1; src1_req = 1; src1_cpl = 0; tx_rdy_vc0 = 1;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(who);
      check($sformatf("alt_g%0d", g), who, g % 2);
      if (who == 0 || who == 1) begin
        drive_src(who, 1, 1);
        #1;
        check($sformatf("alt_end%0d", g), tx_end_vc0, 1);
        tick();
        drive_src(who, 0, 0);
        check($sformatf("alt_gap%0d", g), busy, 0);
      end
    end

    // failed credit recheck while requesting
    do_reset();
    src1_req = 1; src1_len = 10'd4; tx_ca_ph_vc0 = 9'd1; tx_ca_pd_vc0 = 13'd1;
    tick();
    check("rc_req", tx_req_vc0, 1);
    tx_ca_ph_vc0 = 9'd0; tx_ca_p_recheck_vc0 = 1; tx_rdy_vc0 = 1;
    tick();
    check("rc_drop", {tx_req_vc0, src1_gnt, busy}, 0);
    tx_ca_p_recheck_vc0 = 0; tx_rdy_vc0 = 0;
    tick();
    check("rc_wait", tx_req_vc0, 0);
    tx_ca_ph_vc0 = 9'd1;
    tick();
    check("rc_req2", tx_req_vc0, 1);
    tx_ca_p_recheck_vc0 = 1; tx_rdy_vc0 = 1;
    tick();
    tx_ca_p_recheck_vc0 = 0; tx_rdy_vc0 = 0; src1_req = 0;
    check("rc_gnt", {tx_req_vc0, src1_gnt}, 2'b01);
    drive_src(1, 1, 1);
    tick();
    drive_src(1, 0, 0);
    check("rc_done", {src1_gnt, busy}, 0);

    // grant timeout: no st from the granted source
    do_reset();
    src0_req = 1; src0_nodata = 1; tx_ca_ph_vc0 = 9'd1; tx_rdy_vc0 = 1;
    src1_st = 1;
    tick();
    tick();
    src0_req = 0; tx_rdy_vc0 = 0;
    cnt_g = 0; cnt_a = 0; abort_at = -1;
    for (int c = 0; c < 80; c++) begin
      if (src0_gnt) cnt_g++;
      if (gnt_abort) begin cnt_a++; if (abort_at < 0) abort_at = c; end
      tick();
    end
    src1_st = 0;
    check("to_gnt_cycles", cnt_g, GNT_TIMEOUT);
    check("to_abort_pulses", cnt_a, 1);
    check("to_abort_when", abort_at, GNT_TIMEOUT);

    // reset in the middle of a stream, then fairness restarts at src0
    do_reset();
    tx_ca_ph_vc0 = 9'h100; tx_ca_pd_vc0 = 13'h1000; tx_ca_cplh_vc0 = 9'h100; tx_ca_cpld_vc0 = 13'h1000;
    tx_rdy_vc0 = 1; src0_req = 1;
    wait_gnt(who);
    check("mr_first", who, 0);
    src0_req = 0;
    drive_src(0, 1, 1);
    tick();
    drive_src(0, 0, 0);
    src1_req = 1;
    wait_gnt(who);
    check("mr_second", who, 1);
    src1_req = 0;
    src1_st = 1;
    #1;
    check("mr_streaming", tx_st_vc0, 1);
    src1_end = 1;
    core_rst_n = 0;
    tick();
    check("mr_rst_out", {tx_req_vc0, src0_gnt, src1_gnt, tx_st_vc0, tx_end_vc0, busy}, 0);
    core_rst_n = 1; src1_st = 0; src1_end = 0;
    src0_req = 1; src1_req = 1;
    wait_gnt(who);
    check("mr_after_rst", who, 0);

    // randomized run against the reference model
    clear_inputs();
    core_rst_n = 0;
    tick();
    model_step();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      randomize_inputs();
      #1;
      e_st   = (m_own >= 0) && s_st(m_own);
      e_end  = (m_own >= 0) && s_end(m_own);
      e_data = (m_own == 1) ? src1_data : ((m_own == 0) ? src0_data : 16'h0000);
      exp_v = {(m_req >= 0), (m_own == 0), (m_own == 1), e_st, e_end,
               (m_req >= 0 || m_own >= 0), m_abort, e_data};
      got_v = {tx_req_vc0, src0_gnt, src1_gnt, tx_st_vc0, tx_end_vc0, busy, gnt_abort, tx_data_vc0};
      check($sformatf("rnd_c%0d", cyc), got_v, exp_v);
      tick();
      model_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
